// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed leaky integrate-and-fire update over N_NEURONS virtual neurons.
// Fetches one input current per neuron per timestep and emits spikes as indexed valid/ready events.
module lif_tdm_scheduler #(
  parameter int N_NEURONS  = 8,
  parameter int IDX_W      = 3,
  parameter int DATA_W     = 8,
  parameter int BETA_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] threshold_i,
  output logic              cur_req_o,
  output logic [IDX_W-1:0]  cur_idx_o,
  input  logic              cur_valid_i,
  input  logic [DATA_W-1:0] cur_data_i,
  output logic              spk_valid_o,
  output logic [IDX_W-1:0]  spk_idx_o,
  input  logic              spk_ready_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic [IDX_W-1:0]  state_rd_idx_i,
  output logic [DATA_W-1:0] state_rd_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_UPDATE = 3'd2,
    S_EMIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [DATA_W-1:0]   thr_r, thr_s;
  logic [DATA_W-1:0]   cur_r, cur_s;
  logic [DATA_W-1:0]   mem_r [N_NEURONS];
  logic                wr_en_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [DATA_W-1:0]   sum_s;
  logic                spike_s;
  logic                cur_req_r, spk_valid_r, busy_r, done_r;
  logic [IDX_W-1:0]    spk_idx_r;

  // Leak then integrate, clamped to the top of the unsigned range.
  function automatic logic [DATA_W-1:0] lif_sum(input logic [DATA_W-1:0] s,
                                                input logic [DATA_W-1:0] cur);
    logic [DATA_W:0] decayed;
    logic [DATA_W:0] sum;
    decayed = {1'b0, s - (s >> BETA_SHIFT)};
    sum     = decayed + {1'b0, cur};
    if (sum[DATA_W]) begin
      lif_sum = {DATA_W{1'b1}};
    end else begin
      lif_sum = sum[DATA_W-1:0];
    end
  endfunction

  assign sum_s   = lif_sum(mem_r[idx_r], cur_r);
  assign spike_s = (sum_s >= thr_r);

  // Next-state, index advance and membrane write decisions.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    thr_s     = thr_r;
    cur_s     = cur_r;
    wr_en_s   = 1'b0;
    wr_data_s = sum_s;
    case (state_r)
      S_IDLE: begin
        if (step_i) begin
          thr_s   = threshold_i;
          idx_s   = {IDX_W{1'b0}};
          state_s = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (cur_valid_i) begin
          cur_s   = cur_data_i;
          state_s = S_UPDATE;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_UPDATE: begin
        wr_en_s = 1'b1;
        if (spike_s) begin
          wr_data_s = sum_s - thr_r;
          state_s   = S_EMIT;
        end else if (idx_r == LAST_IDX) begin
          state_s = S_DONE;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          state_s = S_FETCH;
        end
      end
      S_EMIT: begin
        if (!spk_ready_i) begin
          state_s = S_EMIT;
        end else if (idx_r == LAST_IDX) begin
          state_s = S_DONE;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          state_s = S_FETCH;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Control registers and membrane store; clear outranks every other update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      thr_r   <= {DATA_W{1'b0}};
      cur_r   <= {DATA_W{1'b0}};
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (clear_i) begin
      state_r <= S_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      thr_r   <= thr_r;
      cur_r   <= cur_r;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      thr_r   <= thr_s;
      cur_r   <= cur_s;
      if (wr_en_s) begin
        mem_r[idx_r] <= wr_data_s;
      end else begin
        mem_r[idx_r] <= mem_r[idx_r];
      end
    end
  end

  // Outputs are decoded from the next state so they switch with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_req_r   <= 1'b0;
      spk_valid_r <= 1'b0;
      spk_idx_r   <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (clear_i) begin
      cur_req_r   <= 1'b0;
      spk_valid_r <= 1'b0;
      spk_idx_r   <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cur_req_r   <= (state_s == S_FETCH);
      spk_valid_r <= (state_s == S_EMIT);
      spk_idx_r   <= (state_s == S_EMIT) ? idx_s : {IDX_W{1'b0}};
      busy_r      <= (state_s != S_IDLE);
      done_r      <= (state_s == S_DONE);
    end
  end

  assign cur_req_o   = cur_req_r;
  assign cur_idx_o   = idx_r;
  assign spk_valid_o = spk_valid_r;
  assign spk_idx_o   = spk_idx_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign state_rd_o  = mem_r[state_rd_idx_i];

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Randomized bench for lif_tdm_scheduler against an array-based LIF reference model.
// Covers reset, nominal steps, saturation, backpressure, clear and mid-step reset.
module tb_lif_tdm_scheduler;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] threshold_i = 8'd0;
  logic       cur_req_o;
  logic [2:0] cur_idx_o;
  logic       cur_valid_i = 1'b0;
  logic [7:0] cur_data_i = 8'd0;
  logic       spk_valid_o;
  logic [2:0] spk_idx_o;
  logic       spk_ready_i = 1'b0;
  logic       busy_o;
  logic       done_o;
  logic [2:0] state_rd_idx_i = 3'd0;
  logic [7:0] state_rd_o;

  int checks = 0;
  int errors = 0;
  int model_state [N];
  int cur_tbl [N];
  int exp_q [$];

  always #5 clk = ~clk;

  lif_tdm_scheduler dut (
    .clk(clk), .rst_n(rst_n), .step_i(step_i), .clear_i(clear_i),
    .threshold_i(threshold_i), .cur_req_o(cur_req_o), .cur_idx_o(cur_idx_o),
    .cur_valid_i(cur_valid_i), .cur_data_i(cur_data_i), .spk_valid_o(spk_valid_o),
    .spk_idx_o(spk_idx_o), .spk_ready_i(spk_ready_i), .busy_o(busy_o),
    .done_o(done_o), .state_rd_idx_i(state_rd_idx_i), .state_rd_o(state_rd_o)
  );

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_states();
    for (int i = 0; i < N; i++) begin
      state_rd_idx_i = 3'(i);
      #1;
      chk_eq($sformatf("state[%0d]", i), int'(state_rd_o), model_state[i]);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) model_state[i] = 0;
  endtask

  // One timestep of the reference model: leak by half, add current, clamp, fire.
  task automatic model_step(input int thr);
    int s, sum;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      s   = model_state[i];
      sum = (s - s / 2) + cur_tbl[i];
      if (sum > 255) sum = 255;
      if (sum >= thr) begin
        model_state[i] = sum - thr;
        exp_q.push_back(i);
      end else begin
        model_state[i] = sum;
      end
    end
  endtask

  // vmode: 0 current always valid, 1 random valid. rmode: 0 always ready, 1 random, 2 hold 5 cycles.
  task automatic run_step(input int thr, input int vmode, input int rmode);
    int cyc, nspk, hold, after_idx, e;
    bit got_done;
    model_step(thr);
    nspk = exp_q.size();
    threshold_i = 8'(thr);
    step_i = 1'b1;
    @(posedge clk); #1;
    step_i = 1'b0;
    threshold_i = 8'($urandom_range(0, 255));
    cyc = 0; hold = 0; got_done = 1'b0;
    while (!got_done && cyc < 600) begin
      cur_valid_i = (vmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      cur_data_i  = 8'(cur_tbl[cur_idx_o]);
      step_i      = (cyc == 3);
      after_idx   = -1;
      if (rmode == 1) begin
        spk_ready_i = 1'($urandom_range(0, 1));
      end else if (rmode == 2 && spk_valid_o && hold < 5) begin
        spk_ready_i = 1'b0;
        hold++;
        chk_eq("bp_cur_req", int'(cur_req_o), 0);
        if (exp_q.size() > 0) chk_eq("bp_spk_idx", int'(spk_idx_o), exp_q[0]);
      end else begin
        spk_ready_i = 1'b1;
      end
      chk_eq("req_spk_excl", int'(cur_req_o & spk_valid_o), 0);
      if (spk_valid_o && spk_ready_i) begin
        chk_eq("spk_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk_eq("spk_idx", int'(spk_idx_o), e);
          if (rmode == 2 && e < N - 1) after_idx = e + 1;
        end
        hold = 0;
      end
      @(posedge clk); #1;
      cyc++;
      if (after_idx >= 0) begin
        chk_eq("bp_next_req", int'(cur_req_o), 1);
        chk_eq("bp_next_idx", int'(cur_idx_o), after_idx);
      end
      if (done_o) got_done = 1'b1;
    end
    step_i = 1'b0;
    chk_eq("done_seen", int'(got_done), 1);
    chk_eq("spikes_left", exp_q.size(), 0);
    if (vmode == 0 && rmode == 0) chk_eq("latency", cyc, 2 * N + nspk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_eq("done_single", int'(done_o), 0);
      chk_eq("idle_busy", int'(busy_o), 0);
    end
    check_states();
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    model_zero();
  endtask

  task automatic fill_tbl(input int v);
    for (int i = 0; i < N; i++) cur_tbl[i] = v;
  endtask

  initial begin
    int n;
    model_zero();
    // Reset values while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_cur_req", int'(cur_req_o), 0);
    chk_eq("rst_spk_valid", int'(spk_valid_o), 0);
    chk_eq("rst_busy", int'(busy_o), 0);
    chk_eq("rst_done", int'(done_o), 0);
    chk_eq("rst_cur_idx", int'(cur_idx_o), 0);
    chk_eq("rst_spk_idx", int'(spk_idx_o), 0);
    check_states();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal: quiet step then an all-spiking step.
    fill_tbl(150);
    run_step(200, 0, 0);
    run_step(200, 0, 0);

    // Saturation.
    do_clear();
    fill_tbl(200);
    run_step(255, 0, 0);
    run_step(255, 0, 0);

    // Backpressure on neuron 3.
    do_clear();
    fill_tbl(10);
    cur_tbl[3] = 150;
    run_step(100, 0, 2);

    // Zero threshold: every neuron fires and keeps its sum.
    fill_tbl(40);
    run_step(0, 0, 0);

    // Randomized steps with random handshakes.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) cur_tbl[i] = $urandom_range(0, 255);
      run_step($urandom_range(0, 255), r % 2, (r / 2) % 2);
    end

    // Clear while updating neuron 5.
    fill_tbl(150);
    threshold_i = 8'd200;
    step_i = 1'b1;
    @(posedge clk); #1;
    step_i = 1'b0;
    cur_valid_i = 1'b1;
    spk_ready_i = 1'b1;
    n = 0;
    while (cur_idx_o != 3'd5 && n < 40) begin
      cur_data_i = 8'(cur_tbl[cur_idx_o]);
      @(posedge clk); #1;
      n++;
    end
    chk_eq("clr_reach_idx5", int'(cur_idx_o), 5);
    do_clear();
    chk_eq("clr_busy", int'(busy_o), 0);
    chk_eq("clr_done", int'(done_o), 0);
    chk_eq("clr_cur_req", int'(cur_req_o), 0);
    chk_eq("clr_cur_idx", int'(cur_idx_o), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_eq("clr_no_done", int'(done_o), 0);
    end
    check_states();

    // Asynchronous reset while a spike waits in EMIT.
    fill_tbl(20);
    threshold_i = 8'd0;
    step_i = 1'b1;
    @(posedge clk); #1;
    step_i = 1'b0;
    spk_ready_i = 1'b0;
    n = 0;
    while (!spk_valid_o && n < 40) begin
      cur_data_i = 8'(cur_tbl[cur_idx_o]);
      @(posedge clk); #1;
      n++;
    end
    chk_eq("emit_reached", int'(spk_valid_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_spk_valid", int'(spk_valid_o), 0);
    chk_eq("arst_busy", int'(busy_o), 0);
    chk_eq("arst_cur_req", int'(cur_req_o), 0);
    chk_eq("arst_done", int'(done_o), 0);
    chk_eq("arst_cur_idx", int'(cur_idx_o), 0);
    model_zero();
    check_states();
    @(posedge clk); #1;
    rst_n = 1'b1;
    spk_ready_i = 1'b1;
    @(posedge clk); #1;
    fill_tbl(150);
    run_step(200, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
